// File: rtl/fitness_collector_if.sv
// Fitness collector bus: energy beats from the evaluator plus the read port.
// Ports: fit_valid_i/fit_energy_i/fit_done_i/fit_bank_i, rd_en_i/rd_bank_i/rd_addr_i -> rd_data_o/rd_valid_o.
interface fitness_collector_if #(
    parameter int SELF_FIT_LENGTH = 10,
    parameter int IDX_WIDTH       = 6
);
    logic                       fit_valid_i;
    logic [SELF_FIT_LENGTH-1:0] fit_energy_i;
    logic                       fit_done_i;
    logic                       fit_bank_i;
    logic                       rd_en_i;
    logic                       rd_bank_i;
    logic [IDX_WIDTH-1:0]       rd_addr_i;
    logic [SELF_FIT_LENGTH-1:0] rd_data_o;
    logic                       rd_valid_o;

    modport master (
        output fit_valid_i,
        output fit_energy_i,
        output fit_done_i,
        output fit_bank_i,
        output rd_en_i,
        output rd_bank_i,
        output rd_addr_i,
        input  rd_data_o,
        input  rd_valid_o
    );

    modport slave (
        input  fit_valid_i,
        input  fit_energy_i,
        input  fit_done_i,
        input  fit_bank_i,
        input  rd_en_i,
        input  rd_bank_i,
        input  rd_addr_i,
        output rd_data_o,
        output rd_valid_o
    );
endinterface

// File: rtl/fitness_collector.sv
// Ping-pong fitness collector: two banks of per-individual energies with
// per-bank fill FSM, running minimum, best-of-population pulse and read port.
// Ports: clk_i, rst_i (async, active-high), bus (fitness_collector_if.slave),
//        bank_release_i, bank_full_o, best_valid_o/energy_o/idx_o/bank_o,
//        overflow_err_o.
module fitness_collector #(
    parameter int SELF_FIT_LENGTH = 10,
    parameter int POP_SIZE        = 50,
    parameter int IDX_WIDTH       = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    fitness_collector_if.slave         bus,
    input  logic [1:0]                 bank_release_i,
    output logic [1:0]                 bank_full_o,
    output logic                       best_valid_o,
    output logic [SELF_FIT_LENGTH-1:0] best_energy_o,
    output logic [IDX_WIDTH-1:0]       best_idx_o,
    output logic                       best_bank_o,
    output logic                       overflow_err_o
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(POP_SIZE - 1);

    logic [SELF_FIT_LENGTH-1:0] mem   [2][POP_SIZE];
    logic [1:0]                 state [2];
    logic [IDX_WIDTH-1:0]       wr_cnt[2];
    logic [SELF_FIT_LENGTH-1:0] min_e [2];
    logic [IDX_WIDTH-1:0]       min_i [2];

    // Completion result is staged one cycle so the pulse trails bank_full_o.
    logic                       pend_valid;
    logic [SELF_FIT_LENGTH-1:0] pend_e;
    logic [IDX_WIDTH-1:0]       pend_i;
    logic                       pend_bank;

    logic                       wb;
    logic [IDX_WIDTH-1:0]       cur_cnt;
    logic                       bank_is_full;
    logic                       accept;
    logic                       drop;
    logic                       take_min;
    logic [SELF_FIT_LENGTH-1:0] nxt_min_e;
    logic [IDX_WIDTH-1:0]       nxt_min_i;
    logic                       completes;
    logic [SELF_FIT_LENGTH-1:0] rd_word;

    always_comb begin
        wb           = bus.fit_bank_i;
        cur_cnt      = wr_cnt[wb];
        bank_is_full = (state[wb] == ST_FULL);
        accept       = bus.fit_valid_i & ~bank_is_full;
        drop         = bus.fit_valid_i & bank_is_full;
        // First beat of a population loads unconditionally; ties keep
        // the earlier (lower) index.
        take_min     = (state[wb] == ST_EMPTY) ||
                       (bus.fit_energy_i < min_e[wb]);
        nxt_min_e    = take_min ? bus.fit_energy_i : min_e[wb];
        nxt_min_i    = take_min ? cur_cnt : min_i[wb];
        completes    = accept & (bus.fit_done_i | (cur_cnt == LAST_IDX));
    end

    always_comb begin
        rd_word = '0;
        if (bus.rd_addr_i <= LAST_IDX) begin
            rd_word = mem[bus.rd_bank_i][bus.rd_addr_i];
        end
    end

    assign bank_full_o[0] = (state[0] == ST_FULL);
    assign bank_full_o[1] = (state[1] == ST_FULL);

    // Storage: cleared on reset, written only by accepted beats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < POP_SIZE; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (accept) begin
            mem[wb][cur_cnt] <= bus.fit_energy_i;
        end
    end

    // Bank FSMs, counters and running minima.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                state[b]  <= ST_EMPTY;
                wr_cnt[b] <= '0;
                min_e[b]  <= '0;
                min_i[b]  <= '0;
            end
        end else begin
            // A release only affects a FULL bank, and a FULL bank never
            // accepts a beat, so release and write never hit the same bank.
            for (int b = 0; b < 2; b++) begin
                if (state[b] == ST_FULL && bank_release_i[b]) begin
                    state[b]  <= ST_EMPTY;
                    wr_cnt[b] <= '0;
                end
            end
            if (accept) begin
                wr_cnt[wb] <= cur_cnt + 1'b1;
                min_e[wb]  <= nxt_min_e;
                min_i[wb]  <= nxt_min_i;
                state[wb]  <= completes ? ST_FULL : ST_FILLING;
            end
        end
    end

    // Completion staging, best-result outputs and sticky overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_valid     <= 1'b0;
            pend_e         <= '0;
            pend_i         <= '0;
            pend_bank      <= 1'b0;
            best_valid_o   <= 1'b0;
            best_energy_o  <= '0;
            best_idx_o     <= '0;
            best_bank_o    <= 1'b0;
            overflow_err_o <= 1'b0;
        end else begin
            pend_valid   <= completes;
            best_valid_o <= pend_valid;
            if (completes) begin
                pend_e    <= nxt_min_e;
                pend_i    <= nxt_min_i;
                pend_bank <= wb;
            end
            if (pend_valid) begin
                best_energy_o <= pend_e;
                best_idx_o    <= pend_i;
                best_bank_o   <= pend_bank;
            end
            if (drop) begin
                overflow_err_o <= 1'b1;
            end
        end
    end

    // Read port: non-blocking capture returns pre-write contents on a
    // same-cycle write; data holds while no read is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.rd_data_o  <= '0;
            bus.rd_valid_o <= 1'b0;
        end else begin
            bus.rd_valid_o <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                bus.rd_data_o <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_fitness_collector.sv
// Testbench for fitness_collector: table-driven beats/reads with a reference
// model feeding scoreboards for best-result pulses and read data.
module tb_fitness_collector;

    localparam int W  = 10;
    localparam int P  = 4;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    bank_release_i;
    logic [1:0]    bank_full_o;
    logic          best_valid_o;
    logic [W-1:0]  best_energy_o;
    logic [IW-1:0] best_idx_o;
    logic          best_bank_o;
    logic          overflow_err_o;

    always #5 clk_i = ~clk_i;

    fitness_collector_if #(.SELF_FIT_LENGTH(W), .IDX_WIDTH(IW)) f ();

    fitness_collector #(
        .SELF_FIT_LENGTH(W),
        .POP_SIZE(P),
        .IDX_WIDTH(IW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(f.slave),
        .bank_release_i(bank_release_i),
        .bank_full_o(bank_full_o),
        .best_valid_o(best_valid_o),
        .best_energy_o(best_energy_o),
        .best_idx_o(best_idx_o),
        .best_bank_o(best_bank_o),
        .overflow_err_o(overflow_err_o)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0]  e;
        logic [IW-1:0] i;
        logic          b;
    } best_t;

    typedef struct {
        logic          v;
        logic          b;
        logic [W-1:0]  e;
        logic          d;
        logic [1:0]    rel;
        logic          re;
        logic          rb;
        logic [IW-1:0] ra;
        logic [1:0]    xfull;
        logic          xovf;
    } vec_t;

    best_t        best_q[$];
    logic [W-1:0] rd_q[$];

    logic [W-1:0]  m_mem [2][P];
    int            m_cnt [2];
    logic          m_full[2];
    logic [W-1:0]  m_min [2];
    logic [IW-1:0] m_idx [2];
    logic          m_ovf;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < P; i++) m_mem[b][i] = '0;
            m_cnt[b]  = 0;
            m_full[b] = 1'b0;
            m_min[b]  = '0;
            m_idx[b]  = '0;
        end
        m_ovf = 1'b0;
    endtask

    task automatic idle_inputs();
        f.fit_valid_i  = 1'b0;
        f.fit_energy_i = '0;
        f.fit_done_i   = 1'b0;
        f.fit_bank_i   = 1'b0;
        f.rd_en_i      = 1'b0;
        f.rd_bank_i    = 1'b0;
        f.rd_addr_i    = '0;
        bank_release_i = 2'b00;
    endtask

    // One clock of stimulus; model updated with pre-edge state, then
    // registered status compared just after the edge.
    task automatic cycle(input logic v, input logic b, input logic [W-1:0] e,
                         input logic d, input logic [1:0] rel,
                         input logic re, input logic rb,
                         input logic [IW-1:0] ra);
        logic       old_full[2];
        int         k;
        logic [1:0] k2;
        logic [1:0] ra2;
        f.fit_valid_i  = v;
        f.fit_bank_i   = b;
        f.fit_energy_i = e;
        f.fit_done_i   = d;
        bank_release_i = rel;
        f.rd_en_i      = re;
        f.rd_bank_i    = rb;
        f.rd_addr_i    = ra;
        ra2 = ra[1:0];
        if (re) rd_q.push_back((int'(ra) < P) ? m_mem[rb][ra2] : '0);
        old_full = m_full;
        if (v) begin
            if (old_full[b]) begin
                m_ovf = 1'b1;
            end else begin
                k  = m_cnt[b];
                k2 = k[1:0];
                m_mem[b][k2] = e;
                if (k == 0 || e < m_min[b]) begin
                    m_min[b] = e;
                    m_idx[b] = k[IW-1:0];
                end
                m_cnt[b] = k + 1;
                if (d || m_cnt[b] == P) begin
                    m_full[b] = 1'b1;
                    best_q.push_back('{m_min[b], m_idx[b], b});
                end
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (rel[j] && old_full[j]) begin
                m_full[j] = 1'b0;
                m_cnt[j]  = 0;
            end
        end
        @(posedge clk_i);
        #1;
        idle_inputs();
        chk("bank_full", 32'(bank_full_o), 32'({m_full[1], m_full[0]}));
        chk("overflow", 32'(overflow_err_o), 32'(m_ovf));
    endtask

    // Scoreboard consumers.
    always @(posedge clk_i) begin
        best_t x;
        logic [W-1:0] r;
        #1;
        if (rst_i === 1'b0) begin
            if (best_valid_o) begin
                if (best_q.size() == 0) begin
                    chk("best_pulse_unexpected", 32'(best_valid_o), 32'd0);
                end else begin
                    x = best_q.pop_front();
                    chk("best_energy", 32'(best_energy_o), 32'(x.e));
                    chk("best_idx", 32'(best_idx_o), 32'(x.i));
                    chk("best_bank", 32'(best_bank_o), 32'(x.b));
                end
            end
            if (f.rd_valid_o) begin
                if (rd_q.size() == 0) begin
                    chk("rd_valid_unexpected", 32'(f.rd_valid_o), 32'd0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_data", 32'(f.rd_data_o), 32'(r));
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_full"}, 32'(bank_full_o), 32'd0);
        chk({tag, "_bvalid"}, 32'(best_valid_o), 32'd0);
        chk({tag, "_benergy"}, 32'(best_energy_o), 32'd0);
        chk({tag, "_bidx"}, 32'(best_idx_o), 32'd0);
        chk({tag, "_bbank"}, 32'(best_bank_o), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_err_o), 32'd0);
        chk({tag, "_rdata"}, 32'(f.rd_data_o), 32'd0);
        chk({tag, "_rvalid"}, 32'(f.rd_valid_o), 32'd0);
    endtask

    initial begin
        //             v  b  e   d  rel   re rb ra  full  ovf
        tbl[0]  = '{1, 0, 9,  0, 2'b00, 0, 0, 0, 2'b00, 0};
        tbl[1]  = '{1, 0, 3,  0, 2'b00, 0, 0, 0, 2'b00, 0};
        tbl[2]  = '{1, 0, 7,  0, 2'b00, 0, 0, 0, 2'b00, 0};
        tbl[3]  = '{1, 0, 3,  1, 2'b00, 0, 0, 0, 2'b01, 0};
        tbl[4]  = '{0, 0, 0,  0, 2'b00, 0, 0, 0, 2'b01, 0};
        tbl[5]  = '{1, 1, 5,  0, 2'b00, 0, 0, 0, 2'b01, 0};
        tbl[6]  = '{1, 1, 2,  1, 2'b00, 0, 0, 0, 2'b11, 0};
        tbl[7]  = '{0, 0, 0,  0, 2'b00, 0, 0, 0, 2'b11, 0};
        tbl[8]  = '{1, 0, 15, 0, 2'b00, 0, 0, 0, 2'b11, 1};
        tbl[9]  = '{0, 0, 0,  0, 2'b00, 1, 0, 2, 2'b11, 1};
        tbl[10] = '{0, 0, 0,  0, 2'b00, 1, 0, 5, 2'b11, 1};
        tbl[11] = '{0, 0, 0,  0, 2'b00, 1, 0, 0, 2'b11, 1};
        tbl[12] = '{0, 0, 0,  0, 2'b01, 1, 0, 3, 2'b10, 1};
        tbl[13] = '{1, 0, 1,  0, 2'b00, 1, 0, 0, 2'b10, 1};
        tbl[14] = '{1, 0, 1,  0, 2'b00, 0, 0, 0, 2'b10, 1};
        tbl[15] = '{1, 0, 1,  0, 2'b00, 0, 0, 0, 2'b10, 1};
        tbl[16] = '{1, 0, 1,  0, 2'b00, 0, 0, 0, 2'b11, 1};
        tbl[17] = '{0, 0, 0,  0, 2'b00, 0, 0, 0, 2'b11, 1};
        tbl[18] = '{0, 0, 0,  0, 2'b11, 0, 0, 0, 2'b00, 1};
        tbl[19] = '{0, 0, 0,  1, 2'b00, 0, 0, 0, 2'b00, 1};
        tbl[20] = '{1, 1, 4,  1, 2'b10, 0, 0, 0, 2'b10, 1};
        tbl[21] = '{0, 0, 0,  0, 2'b00, 0, 0, 0, 2'b10, 1};
        tbl[22] = '{1, 1, 8,  0, 2'b10, 0, 0, 0, 2'b00, 1};
        tbl[23] = '{1, 1, 6,  1, 2'b00, 0, 0, 0, 2'b10, 1};
        tbl[24] = '{0, 0, 0,  0, 2'b00, 0, 0, 0, 2'b10, 1};

        model_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].e, tbl[i].d, tbl[i].rel,
                  tbl[i].re, tbl[i].rb, tbl[i].ra);
            chk($sformatf("tbl%0d_full", i), 32'(bank_full_o),
                32'(tbl[i].xfull));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow_err_o),
                32'(tbl[i].xovf));
        end

        // Reset mid-population: two beats, then async reset mid-cycle.
        cycle(1, 0, 9, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 8, 0, 2'b00, 0, 0, 0);
        chk("pre_reset_best_q", 32'(best_q.size()), 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle(1, 0, 6, 1, 2'b00, 0, 0, 0);
        cycle(0, 0, 0, 0, 2'b00, 1, 0, 1);
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 2'b00, 0, 0, 0);

        chk("best_q_drained", 32'(best_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
